// File: rtl/mxn_unshift_seq_if.sv
// Handshake and lane buses of the sequential shift-undo block.
// The slave modport is the block's view; the master modport is the producer/consumer side.
interface mxn_unshift_seq_if #(
  parameter int WIDTH = 4,
  parameter int SETS  = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [SETS*WIDTH-1:0] shifted_packed;
  logic [SETS*WIDTH-1:0] overflow_packed;
  logic [SETS*WIDTH-1:0] shift_packed;
  logic                  out_valid;
  logic                  out_ready;
  logic [SETS*WIDTH-1:0] restored_packed;
  logic [SETS-1:0]       error_packed;

  modport master (
    output in_valid, shifted_packed, overflow_packed, shift_packed, out_ready,
    input  in_ready, out_valid, restored_packed, error_packed
  );

  modport slave (
    input  in_valid, shifted_packed, overflow_packed, shift_packed, out_ready,
    output in_ready, out_valid, restored_packed, error_packed
  );
endinterface

// File: rtl/mxn_unshift_seq.sv
// Undoes a per-lane barrel shift one bit per cycle, refilling each lane from its
// overflow word and flagging lanes whose vacated bits disagree with the fill bit.
module mxn_unshift_seq #(
  parameter int WIDTH = 4,
  parameter int SETS  = 2
) (
  input  logic               clk,
  input  logic               rst,
  mxn_unshift_seq_if.slave   bus
);
  localparam int IDXW = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int CNTW = WIDTH - 2;
  localparam int BUSW = SETS * WIDTH;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state_q,    state_d;
  logic [IDXW-1:0]  idx_q,      idx_d;
  logic [CNTW-1:0]  cnt_q,      cnt_d;
  logic [WIDTH-1:0] acc_q,      acc_d;
  logic [WIDTH-1:0] ovf_q,      ovf_d;
  logic             dir_q,      dir_d;
  logic             fill_q,     fill_d;
  logic [BUSW-1:0]  shifted_q,  shifted_d;
  logic [BUSW-1:0]  overflow_q, overflow_d;
  logic [BUSW-1:0]  shift_q,    shift_d;
  logic [BUSW-1:0]  restored_q, restored_d;
  logic [SETS-1:0]  error_q,    error_d;

  logic [WIDTH-1:0] laneShf, laneOvf, laneCtl;
  logic [CNTW-1:0]  laneN;
  logic             laneIllegal;
  logic [WIDTH-1:0] accShift, ovfShift;
  logic             dropBit;
  logic             storeEn, errSet, advance;
  logic [WIDTH-1:0] storeVal;

  // Select the current lane's words and build one shift step in the latched direction.
  always_comb begin
    laneShf = '0;
    laneOvf = '0;
    laneCtl = '0;
    for (int i = 0; i < SETS; i++) begin
      if (idx_q == IDXW'(i)) begin
        laneShf = shifted_q[i*WIDTH +: WIDTH];
        laneOvf = overflow_q[i*WIDTH +: WIDTH];
        laneCtl = shift_q[i*WIDTH +: WIDTH];
      end
    end
    laneN       = laneCtl[WIDTH-2:1];
    laneIllegal = (int'(laneN) > WIDTH - 1);

    if (!dir_q) begin
      accShift = {ovf_q[0], acc_q[WIDTH-1:1]};
      ovfShift = ovf_q >> 1;
      dropBit  = acc_q[0];
    end else begin
      accShift = {acc_q[WIDTH-2:0], ovf_q[WIDTH-1]};
      ovfShift = ovf_q << 1;
      dropBit  = acc_q[WIDTH-1];
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    dir_d      = dir_q;
    fill_d     = fill_q;
    shifted_d  = shifted_q;
    overflow_d = overflow_q;
    shift_d    = shift_q;
    restored_d = restored_q;
    error_d    = error_q;
    storeEn    = 1'b0;
    storeVal   = laneShf;
    errSet     = 1'b0;
    advance    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          shifted_d  = bus.shifted_packed;
          overflow_d = bus.overflow_packed;
          shift_d    = bus.shift_packed;
          idx_d      = '0;
          error_d    = '0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        acc_d  = laneShf;
        ovf_d  = laneOvf;
        dir_d  = laneCtl[0];
        fill_d = laneCtl[WIDTH-1];
        cnt_d  = laneN;
        // An out-of-range amount passes the lane through untouched and costs no shift cycles.
        if (laneIllegal || laneN == '0) begin
          errSet  = laneIllegal;
          storeEn = 1'b1;
          advance = 1'b1;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d  = accShift;
        ovf_d  = ovfShift;
        errSet = (dropBit != fill_q);
        cnt_d  = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          storeEn  = 1'b1;
          storeVal = accShift;
          advance  = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < SETS; i++) begin
      if (idx_q == IDXW'(i)) begin
        if (storeEn) restored_d[i*WIDTH +: WIDTH] = storeVal;
        if (errSet)  error_d[i] = 1'b1;
      end
    end

    if (advance) begin
      if (idx_q == IDXW'(SETS - 1)) begin
        state_d = DONE;
      end else begin
        idx_d   = idx_q + IDXW'(1);
        state_d = LOAD;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      ovf_q      <= '0;
      dir_q      <= 1'b0;
      fill_q     <= 1'b0;
      shifted_q  <= '0;
      overflow_q <= '0;
      shift_q    <= '0;
      restored_q <= '0;
      error_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      dir_q      <= dir_d;
      fill_q     <= fill_d;
      shifted_q  <= shifted_d;
      overflow_q <= overflow_d;
      shift_q    <= shift_d;
      restored_q <= restored_d;
      error_q    <= error_d;
    end
  end

  assign bus.in_ready        = (state_q == IDLE);
  assign bus.out_valid       = (state_q == DONE);
  assign bus.restored_packed = restored_q;
  assign bus.error_packed    = error_q;
endmodule

// File: tb/tb_mxn_unshift_seq.sv
// Self-checking bench for mxn_unshift_seq: fixed vectors, handshake/reset corner
// sequences, and random transactions against a concatenate-and-shift reference.
module tb_mxn_unshift_seq;
  localparam int WIDTH = 4;
  localparam int SETS  = 2;
  localparam int BUSW  = WIDTH * SETS;

  typedef struct {
    logic [BUSW-1:0] shf;
    logic [BUSW-1:0] ovf;
    logic [BUSW-1:0] sh;
    logic [BUSW-1:0] expRes;
    logic [SETS-1:0] expErr;
    int              expLat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mxn_unshift_seq_if #(.WIDTH(WIDTH), .SETS(SETS)) bus ();
  mxn_unshift_seq #(.WIDTH(WIDTH), .SETS(SETS)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Undo a lane shift by concatenating overflow and data and shifting the pair back by n.
  function automatic void refModel(input logic [BUSW-1:0] shf, input logic [BUSW-1:0] ovf,
                                   input logic [BUSW-1:0] sh, output logic [BUSW-1:0] res,
                                   output logic [SETS-1:0] err, output int lat);
    logic [WIDTH-1:0]   s, o, c;
    logic [2*WIDTH-1:0] wide;
    int                 n;
    res = '0;
    err = '0;
    lat = SETS;
    for (int i = 0; i < SETS; i++) begin
      s = shf[i*WIDTH +: WIDTH];
      o = ovf[i*WIDTH +: WIDTH];
      c = sh[i*WIDTH +: WIDTH];
      n = int'(c[WIDTH-2:1]);
      if (n > WIDTH - 1) begin
        err[i] = 1'b1;
        res[i*WIDTH +: WIDTH] = s;
      end else begin
        lat += n;
        if (c[0] == 1'b0) begin
          wide = {o, s} >> n;
          res[i*WIDTH +: WIDTH] = wide[WIDTH-1:0];
          for (int k = 0; k < n; k++) if (s[k] != c[WIDTH-1]) err[i] = 1'b1;
        end else begin
          wide = {s, o} << n;
          res[i*WIDTH +: WIDTH] = wide[2*WIDTH-1:WIDTH];
          for (int k = 0; k < n; k++) if (s[WIDTH-1-k] != c[WIDTH-1]) err[i] = 1'b1;
        end
      end
    end
  endfunction

  // Called #1 after a rising edge with the block idle; returns once the DONE handshake is done.
  task automatic applyStimulus(input logic [BUSW-1:0] shf, input logic [BUSW-1:0] ovf,
                               input logic [BUSW-1:0] sh, input int holdCycles,
                               output logic [BUSW-1:0] res, output logic [SETS-1:0] err,
                               output int lat);
    logic timedOut;
    checkOutput("in_ready idle", bus.in_ready, 1'b1);
    bus.shifted_packed  = shf;
    bus.overflow_packed = ovf;
    bus.shift_packed    = sh;
    bus.in_valid        = 1'b1;
    bus.out_ready       = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat      = 0;
    timedOut = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat      = c;
        timedOut = 1'b0;
        break;
      end
    end
    checkOutput("out_valid timeout", timedOut, 1'b0);
    res = bus.restored_packed;
    err = bus.error_packed;
    checkOutput("in_ready in DONE", bus.in_ready, 1'b0);
    for (int h = 0; h < holdCycles; h++) begin
      @(posedge clk);
      #1;
      checkOutput("hold out_valid", bus.out_valid, 1'b1);
      checkOutput("hold restored", bus.restored_packed, res);
      checkOutput("hold error", bus.error_packed, err);
      checkOutput("hold in_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    checkOutput("out_valid after ack", bus.out_valid, 1'b0);
    checkOutput("in_ready after ack", bus.in_ready, 1'b1);
  endtask

  vec_t            vecs[3];
  logic [BUSW-1:0] gotRes, expRes;
  logic [SETS-1:0] gotErr, expErr;
  int              gotLat, expLat;
  int              accepts, results, hold;

  initial begin
    vecs[0] = '{8'hBC, 8'h02, 8'hB4, 8'h6B, 2'b00, 5};
    vecs[1] = '{8'h3C, 8'h02, 8'hB4, 8'h6B, 2'b10, 5};
    vecs[2] = '{8'hA5, 8'h00, 8'h00, 8'hA5, 2'b00, 2};

    rst                 = 1'b1;
    bus.in_valid        = 1'b0;
    bus.out_ready       = 1'b0;
    bus.shifted_packed  = '0;
    bus.overflow_packed = '0;
    bus.shift_packed    = '0;
    #12;
    checkOutput("reset out_valid", bus.out_valid, 1'b0);
    checkOutput("reset restored", bus.restored_packed, '0);
    checkOutput("reset error", bus.error_packed, '0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 checkOutput("reset in_ready", bus.in_ready, 1'b1);

    for (int v = 0; v < 3; v++) begin
      applyStimulus(vecs[v].shf, vecs[v].ovf, vecs[v].sh, 0, gotRes, gotErr, gotLat);
      checkOutput($sformatf("vec%0d restored", v), gotRes, vecs[v].expRes);
      checkOutput($sformatf("vec%0d error", v), gotErr, vecs[v].expErr);
      checkOutput($sformatf("vec%0d latency", v), gotLat, vecs[v].expLat);
    end

    // Consumer stalls for four cycles.
    applyStimulus(8'hBC, 8'h02, 8'hB4, 4, gotRes, gotErr, gotLat);
    checkOutput("stall restored", gotRes, 8'h6B);

    // Reset in the third cycle of a transaction.
    bus.shifted_packed  = 8'hBC;
    bus.overflow_packed = 8'h02;
    bus.shift_packed    = 8'hB4;
    bus.in_valid        = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    checkOutput("midrst out_valid", bus.out_valid, 1'b0);
    checkOutput("midrst restored", bus.restored_packed, '0);
    checkOutput("midrst error", bus.error_packed, '0);
    @(negedge clk) rst = 1'b0;
    results = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1 if (bus.out_valid) results++;
    end
    checkOutput("midrst no out_valid", results, 0);
    applyStimulus(8'hBC, 8'h02, 8'hB4, 0, gotRes, gotErr, gotLat);
    checkOutput("postrst restored", gotRes, 8'h6B);
    checkOutput("postrst error", gotErr, 2'b00);

    // in_valid held high across two back-to-back transactions.
    bus.shifted_packed  = 8'h3C;
    bus.overflow_packed = 8'h02;
    bus.shift_packed    = 8'hB4;
    bus.in_valid        = 1'b1;
    bus.out_ready       = 1'b1;
    accepts = 0;
    results = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.in_valid && bus.in_ready) accepts++;
      if (bus.out_valid) begin
        results++;
        checkOutput("b2b restored", bus.restored_packed, 8'h6B);
        checkOutput("b2b error", bus.error_packed, 2'b10);
        checkOutput("b2b in_ready", bus.in_ready, 1'b0);
      end
      @(posedge clk);
      #1 if (accepts == 2) bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b0;
    checkOutput("b2b accepts", accepts, 2);
    checkOutput("b2b results", results, 2);

    for (int r = 0; r < 40; r++) begin
      bus.shifted_packed = '0;
      hold = int'($urandom_range(0, 2));
      refModel(BUSW'($urandom), BUSW'($urandom), BUSW'($urandom), expRes, expErr, expLat);
      applyStimulus(BUSW'($urandom), BUSW'($urandom), BUSW'($urandom), 0, gotRes, gotErr, gotLat);
      break;
    end

    for (int r = 0; r < 40; r++) begin
      logic [BUSW-1:0] rs, ro, rc;
      rs   = BUSW'($urandom);
      ro   = BUSW'($urandom);
      rc   = BUSW'($urandom);
      hold = int'($urandom_range(0, 2));
      refModel(rs, ro, rc, expRes, expErr, expLat);
      applyStimulus(rs, ro, rc, hold, gotRes, gotErr, gotLat);
      checkOutput($sformatf("rand%0d restored", r), gotRes, expRes);
      checkOutput($sformatf("rand%0d error", r), gotErr, expErr);
      checkOutput($sformatf("rand%0d latency", r), gotLat, expLat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
